// File: rtl/sr_deb_pkg.sv
// Shared types and constants for the two-channel set/clear button debouncer.
package sr_deb_pkg;

  localparam int SYNC_STAGES = 2;

  typedef logic [1:0] chan_state_t;

  localparam chan_state_t LOW    = 2'd0;
  localparam chan_state_t ARM_HI = 2'd1;
  localparam chan_state_t HIGH   = 2'd2;
  localparam chan_state_t ARM_LO = 2'd3;

endpackage

// File: rtl/sr_input_debouncer_if.sv
// Button/latch-drive bundle for sr_input_debouncer; q_mirror exists only with SR_DEB_MIRROR_EN.
interface sr_input_debouncer_if;

  logic set_btn;
  logic clr_btn;
  logic s_out;
  logic r_out;
  logic conflict;
  logic busy;
`ifdef SR_DEB_MIRROR_EN
  logic q_mirror;

  modport master (output set_btn, clr_btn, input s_out, r_out, conflict, busy, q_mirror);
  modport slave  (input set_btn, clr_btn, output s_out, r_out, conflict, busy, q_mirror);
`else
  modport master (output set_btn, clr_btn, input s_out, r_out, conflict, busy);
  modport slave  (input set_btn, clr_btn, output s_out, r_out, conflict, busy);
`endif

endinterface

// File: rtl/deb_channel.sv
// One debounce channel: 2-flop synchronizer, LOW/ARM_HI/HIGH/ARM_LO FSM and qualification counter.
module deb_channel
  import sr_deb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise,
  output logic busy
);

  // The entry edge into an ARM state is the first stable sample, so the
  // counter only has to reach DEBOUNCE_CYCLES-2 to cover the full window.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [SYNC_STAGES-1:0] sync;
  logic                   din;
  chan_state_t            state;
  logic [CNT_W-1:0]       cnt;

  assign din  = sync[SYNC_STAGES-1];
  assign busy = (state == ARM_HI) || (state == ARM_LO);

  always_ff @(posedge clk) begin
    // NOTE: every register here, synchronizer included, is reset so a button held through reset requalifies from scratch.
    if (rst) begin
      sync  <= '0;
      state <= LOW;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn};
      rise <= 1'b0;
      case (state)
        LOW: begin
          if (din) begin
            state <= ARM_HI;
            cnt   <= '0;
          end
        end
        ARM_HI: begin
          if (!din) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt >= LAST) begin
            state <= HIGH;
            cnt   <= '0;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HIGH: begin
          if (!din) begin
            state <= ARM_LO;
            cnt   <= '0;
          end
        end
        ARM_LO: begin
          // Release qualifies silently: no strobe on the way back to LOW.
          if (din) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt >= LAST) begin
            state <= LOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sr_input_debouncer.sv
// Debounces set/clear buttons into exclusive one-cycle S/R pulses for a NOR SR latch.
// Optional SR_DEB_MIRROR_EN adds q_mirror, the expected latch state.
module sr_input_debouncer
  import sr_deb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input logic                 clk,
  input logic                 rst,
  sr_input_debouncer_if.slave deb
);

  logic set_rise, clr_rise;
  logic set_busy, clr_busy;
  logic s_q, r_q, conflict_q;

  deb_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_set (
    .clk  (clk),
    .rst  (rst),
    .btn  (deb.set_btn),
    .rise (set_rise),
    .busy (set_busy)
  );

  deb_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clr (
    .clk  (clk),
    .rst  (rst),
    .btn  (deb.clr_btn),
    .rise (clr_rise),
    .busy (clr_busy)
  );

  // Simultaneous accepts are suppressed so the latch never sees S=R=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      s_q        <= set_rise & ~clr_rise;
      r_q        <= clr_rise & ~set_rise;
      conflict_q <= set_rise & clr_rise;
    end
  end

  assign deb.s_out    = s_q;
  assign deb.r_out    = r_q;
  assign deb.conflict = conflict_q;
  assign deb.busy     = set_busy | clr_busy;

`ifdef SR_DEB_MIRROR_EN
  logic q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else if (s_q) begin
      q_q <= 1'b1;
    end else if (r_q) begin
      q_q <= 1'b0;
    end
  end

  assign deb.q_mirror = q_q;
`endif

endmodule

// File: tb/tb_sr_input_debouncer.sv
// Self-checking bench for sr_input_debouncer with DEBOUNCE_CYCLES=4: directed scenarios plus random buttons.
module tb_sr_input_debouncer;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sr_input_debouncer_if bus ();

  sr_input_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .deb (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level flips once the synchronized input has disagreed
  // with it for D consecutive samples; a 0->1 flip is an accepted press.
  logic ms1, ms2, mc1, mc2;
  logic lvl_s, lvl_c, rise_s, rise_c;
  int   run_s, run_c;
  logic e_s, e_r, e_cf, e_q;
  int   edge_no;

  int s_cnt, r_cnt, cf_cnt, s_edge, r_edge, cf_edge, busy_seen;

  task automatic chan_model(input logic s, inout logic lvl, inout int run, output logic rise);
    rise = 1'b0;
    if (s == lvl) begin
      run = 0;
    end else begin
      run++;
      if (run == D) begin
        lvl  = s;
        run  = 0;
        rise = s;
      end
    end
  endtask

  task automatic model_edge(input logic r, input logic sv, input logic cv);
    if (r) begin
      {ms1, ms2, mc1, mc2} = '0;
      {lvl_s, lvl_c, rise_s, rise_c} = '0;
      run_s = 0;
      run_c = 0;
      {e_s, e_r, e_cf, e_q} = '0;
      edge_no = 0;
    end else begin
      edge_no++;
      if (e_s) e_q = 1'b1;
      else if (e_r) e_q = 1'b0;
      e_s  = rise_s & ~rise_c;
      e_r  = rise_c & ~rise_s;
      e_cf = rise_s & rise_c;
      chan_model(ms2, lvl_s, run_s, rise_s);
      chan_model(mc2, lvl_c, run_c, rise_c);
      ms2 = ms1;
      ms1 = sv;
      mc2 = mc1;
      mc1 = cv;
    end
  endtask

  task automatic clear_stats();
    s_cnt = 0; r_cnt = 0; cf_cnt = 0;
    s_edge = -1; r_edge = -1; cf_edge = -1;
    busy_seen = 0;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
  task automatic step(input logic r, input logic sv, input logic cv);
    rst         = r;
    bus.set_btn = sv;
    bus.clr_btn = cv;
    @(posedge clk);
    model_edge(r, sv, cv);
    #1;
    check("s_out", bus.s_out, e_s);
    check("r_out", bus.r_out, e_r);
    check("conflict", bus.conflict, e_cf);
    check("busy", bus.busy, (run_s != 0) || (run_c != 0));
    check("s_r_exclusive", bus.s_out & bus.r_out, 1'b0);
`ifdef SR_DEB_MIRROR_EN
    check("q_mirror", bus.q_mirror, e_q);
`endif
    if (bus.s_out) begin
      s_cnt++;
      if (s_edge < 0) s_edge = edge_no;
    end
    if (bus.r_out) begin
      r_cnt++;
      if (r_edge < 0) r_edge = edge_no;
    end
    if (bus.conflict) begin
      cf_cnt++;
      if (cf_edge < 0) cf_edge = edge_no;
    end
    if (bus.busy) busy_seen = 1;
  endtask

  task automatic do_reset(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0);
    clear_stats();
  endtask

  initial begin
    logic sv, cv;
    logic [8:0] bounce;
    rst         = 1'b1;
    bus.set_btn = 1'b0;
    bus.clr_btn = 1'b0;
    model_edge(1'b1, 1'b0, 1'b0);
    clear_stats();

    // Reset state
    do_reset(3);
    check("rst_s_out", bus.s_out, 1'b0);
    check("rst_r_out", bus.r_out, 1'b0);
    check("rst_conflict", bus.conflict, 1'b0);
    check("rst_busy", bus.busy, 1'b0);

    // Clean press, held 20 cycles, then released
    repeat (20) step(1'b0, 1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0);
    check("clean_s_edge", s_edge, 7);
    check("clean_s_count", s_cnt, 1);
    check("clean_r_count", r_cnt, 0);

    // Bounce on clear: 1,0,1,0 in 2-cycle phases, then held
    do_reset(3);
    bounce = 9'b1_0011_0011;
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, bounce[i]);
    check("bounce_no_early_r", r_cnt, 0);
    check("bounce_busy_seen", busy_seen, 1);
    repeat (12) step(1'b0, 1'b0, 1'b1);
    check("bounce_r_edge", r_edge, 15);
    check("bounce_r_count", r_cnt, 1);

    // Simultaneous press
    do_reset(3);
    repeat (15) step(1'b0, 1'b1, 1'b1);
    check("simul_cf_edge", cf_edge, 7);
    check("simul_cf_count", cf_cnt, 1);
    check("simul_s_count", s_cnt, 0);
    check("simul_r_count", r_cnt, 0);

    // Last press wins: set accepted and held, then clear pressed
    do_reset(3);
    repeat (10) step(1'b0, 1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b1, 1'b1);
    check("lpw_s_count", s_cnt, 1);
    check("lpw_r_count", r_cnt, 1);
    check("lpw_r_edge", r_edge, 17);

    // Reset mid-qualification, button kept high
    do_reset(3);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("midrst_no_pulse", s_cnt, 0);
    clear_stats();
    repeat (12) step(1'b0, 1'b1, 1'b0);
    check("midrst_s_edge", s_edge, 7);
    check("midrst_s_count", s_cnt, 1);

    // Random buttons with occasional reset
    do_reset(2);
    sv = 1'b0;
    cv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) sv = ~sv;
      if ($urandom_range(0, 5) == 0) cv = ~cv;
      step(($urandom_range(0, 299) == 0), sv, cv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
